mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbitrates one shared 64-bit memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between the pipeline and the unified memory model/bus. Only one transaction is outstanding at a time.
- The memory stage normally has priority, with anti-starvation for fetch.
- A fetch flush (branch redirect) silently drops in-flight instruction responses.

Parameters:
- ADDR_W, 64, address width for all ports.
- MAX_STARVE, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win.
- TIMEOUT_CYCLES, 256, wait-for-response cycle limit; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IF_REQ  in  1  fetch read request; held until IF_ACK.
- IF_ADDR  in  ADDR_W  fetch byte address.
- IF_ACK  out  1  one-cycle pulse: fetch request latched.
- IF_RVALID  out  1  one-cycle pulse: instruction returned.
- IF_RDATA  out  32  instruction word.
- MEM_REQ  in  1  data request; held until MEM_ACK.
- MEM_WE  in  1  1 = store, 0 = load.
- MEM_ADDR  in  ADDR_W  data byte address.
- MEM_WDATA  in  64  store data.
- MEM_WSTRB  in  8  store byte enables.
- MEM_ACK  out  1  one-cycle pulse: data request latched.
- MEM_RVALID  out  1  one-cycle pulse: load data or store completion.
- MEM_RDATA  out  64  load data; 0 for stores.
- FLUSH  in  1  fetch redirect; cancels pending or in-flight fetch only.
- P_REQ  out  1  port request.
- P_WE  out  1  port write enable.
- P_ADDR  out  ADDR_W  port address, 8-byte aligned (low 3 bits forced to 0).
- P_WDATA  out  64  port write data.
- P_WSTRB  out  8  port byte enables; 0 on reads.
- P_READY  in  1  port accepts the request when P_REQ & P_READY.
- P_RVALID  in  1  one response per accepted request, at least 1 cycle after acceptance.
- P_RDATA  in  64  port read data.
- BUS_ERR  out  1  one-cycle pulse coincident with the owner's RVALID on timeout.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (RESET = 0, asynchronous): state IDLE; starve_cnt, drop flag, owner and watchdog counter cleared; all outputs 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE grant decision, evaluated combinationally from registered state:
  - Only MEM_REQ: grant data.
  - Only IF_REQ with FLUSH = 0: grant fetch.
  - Both requesting: grant data unless starve_cnt == MAX_STARVE, then grant fetch.
  - IF_REQ with FLUSH = 1 in the same cycle: no fetch grant, no IF_ACK.
- On a grant: pulse that requester's ACK this cycle, latch address/we/wdata/wstrb and the owner, go to ISSUE. Latched fields are registered; P_* outputs become valid the cycle after ACK.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) on each data grant while IF_REQ = 1.
  - Cleared on a fetch grant or in any IDLE cycle with IF_REQ = 0.
- ISSUE: P_REQ = 1 with stable fields until P_READY. Requests are never withdrawn; FLUSH here sets the drop flag only. On P_READY go to WAIT and clear the watchdog.
- WAIT: P_REQ = 0; watchdog increments each cycle. On P_RVALID, register the response and go to IDLE. The owner's RVALID/RDATA appear the next cycle (1-cycle registered latency).
- Fetch data: IF_RDATA = P_RDATA[63:32] if latched IF_ADDR[2] = 1, else P_RDATA[31:0].
- Drop flag:
  - Set by FLUSH in ISSUE or WAIT while the owner is fetch.
  - When set, the response is consumed, IF_RVALID stays 0, and the flag clears on return to IDLE.
  - FLUSH never affects data transactions.
- Watchdog: if the count reaches TIMEOUT_CYCLES in WAIT, the owner's RVALID = 1 with RDATA = 0 and BUS_ERR = 1, then IDLE. A late P_RVALID arriving in IDLE is ignored.
- Back-to-back: a new grant is possible in the IDLE cycle after a response, so minimum transaction spacing is 3 cycles with P_READY = 1 and 1-cycle memory latency.
- P_RVALID arriving in IDLE or ISSUE is ignored.

Test Plan:
- Single fetch: IF_REQ = 1, IF_ADDR = 0x1004, P_READY = 1, P_RDATA = 0xAAAA_BBBB_CCCC_DDDD one cycle after acceptance.
  -> P_ADDR = 0x1000; IF_RVALID = 1 with IF_RDATA = 0xAAAABBBB one cycle after P_RVALID.
- Store: MEM_REQ = 1, MEM_WE = 1, MEM_ADDR = 0x2008, WSTRB = 0x0F, WDATA = 0x1122334455667788.
  -> P_WE = 1, P_WSTRB = 0x0F, P_WDATA matches; MEM_RVALID = 1, MEM_RDATA = 0.
- Contention: IF_REQ and MEM_REQ held with MAX_STARVE = 4 and a new data request every IDLE.
  -> grant order is 4 data grants, then fetch; starve_cnt returns to 0.
- Flush in WAIT: fetch accepted, FLUSH pulsed, P_RVALID arrives 3 cycles later.
  -> IF_RVALID stays 0, BUSY drops, next data request granted normally.
- Timeout: TIMEOUT_CYCLES = 8, load accepted, no P_RVALID.
  -> after 8 WAIT cycles MEM_RVALID = 1, MEM_RDATA = 0, BUS_ERR = 1, state IDLE.
- Async reset mid-WAIT: RESET low between clock edges.
  -> all outputs 0 immediately; after release, IF_REQ is granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between fetch and data.
// Data wins by default, fetch is forced after MAX_STARVE data grants.
// Ports: IF_* fetch side, MEM_* data side, P_* shared port, FLUSH drops
// in-flight fetch responses, BUS_ERR flags a watchdog timeout, BUSY != IDLE.
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int MAX_STARVE     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic              IF_RVALID,
  output logic [31:0]       IF_RDATA,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [63:0]       MEM_WDATA,
  input  logic [7:0]        MEM_WSTRB,
  output logic              MEM_ACK,
  output logic              MEM_RVALID,
  output logic [63:0]       MEM_RDATA,
  input  logic              FLUSH,
  output logic              P_REQ,
  output logic              P_WE,
  output logic [ADDR_W-1:0] P_ADDR,
  output logic [63:0]       P_WDATA,
  output logic [7:0]        P_WSTRB,
  input  logic              P_READY,
  input  logic              P_RVALID,
  input  logic [63:0]       P_RDATA,
  output logic              BUS_ERR,
  output logic              BUSY
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [WW-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic              drop_q, drop_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              mem_rvalid_q, mem_rvalid_d;
  logic [63:0]       mem_rdata_q, mem_rdata_d;
  logic              bus_err_q, bus_err_d;

  logic grant_if, grant_mem;
  logic fetch_ok, dropping, timeout;
  logic unused_bits;

  assign fetch_ok = IF_REQ & ~FLUSH;
  assign dropping = drop_q | (FLUSH & owner_q);
  assign timeout  = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    drop_d       = drop_q;
    starve_d     = starve_q;
    wd_d         = wd_q;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rvalid_d = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    bus_err_d    = 1'b0;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        // fetch only overrides data once it has been passed over enough
        if (MEM_REQ && !(fetch_ok && starve_q == STARVE_MAX))
          grant_mem = 1'b1;
        else if (fetch_ok)
          grant_if = 1'b1;
        if (grant_mem) begin
          owner_d = 1'b0;
          we_d    = MEM_WE;
          hi_d    = 1'b0;
          addr_d  = {MEM_ADDR[ADDR_W-1:3], 3'b000};
          wdata_d = MEM_WE ? MEM_WDATA : 64'd0;
          wstrb_d = MEM_WE ? MEM_WSTRB : 8'd0;
          state_d = S_ISSUE;
        end else if (grant_if) begin
          owner_d = 1'b1;
          we_d    = 1'b0;
          hi_d    = IF_ADDR[2];
          addr_d  = {IF_ADDR[ADDR_W-1:3], 3'b000};
          wdata_d = 64'd0;
          wstrb_d = 8'd0;
          state_d = S_ISSUE;
        end
        if (!IF_REQ || grant_if)
          starve_d = '0;
        else if (grant_mem && starve_q != STARVE_MAX)
          starve_d = starve_q + 1'b1;
      end
      S_ISSUE: begin
        if (FLUSH && owner_q) drop_d = 1'b1;
        if (P_READY) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        if (FLUSH && owner_q) drop_d = 1'b1;
        wd_d = wd_q + 1'b1;
        if (P_RVALID) begin
          state_d = S_IDLE;
          if (owner_q) begin
            if_rvalid_d = ~dropping;
            if_rdata_d  = hi_q ? P_RDATA[63:32] : P_RDATA[31:0];
          end else begin
            mem_rvalid_d = 1'b1;
            mem_rdata_d  = we_q ? 64'd0 : P_RDATA;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          if (owner_q) begin
            if_rvalid_d = ~dropping;
            if_rdata_d  = 32'd0;
            bus_err_d   = ~dropping;
          end else begin
            mem_rvalid_d = 1'b1;
            mem_rdata_d  = 64'd0;
            bus_err_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      hi_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      drop_q       <= 1'b0;
      starve_q     <= '0;
      wd_q         <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      hi_q         <= hi_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      drop_q       <= drop_d;
      starve_q     <= starve_d;
      wd_q         <= wd_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // ACKs are combinational; gate them so reset silences every output
  assign IF_ACK     = grant_if & RESET;
  assign MEM_ACK    = grant_mem & RESET;
  assign IF_RVALID  = if_rvalid_q;
  assign IF_RDATA   = if_rdata_q;
  assign MEM_RVALID = mem_rvalid_q;
  assign MEM_RDATA  = mem_rdata_q;
  assign BUS_ERR    = bus_err_q;
  assign BUSY       = (state_q != S_IDLE);
  assign P_REQ      = (state_q == S_ISSUE);
  assign P_WE       = we_q;
  assign P_ADDR     = addr_q;
  assign P_WDATA    = wdata_q;
  assign P_WSTRB    = wstrb_q;

  assign unused_bits = ^{IF_ADDR[1:0], MEM_ADDR[2:0]};

endmodule
